// File: rtl/writeback_regfile.sv
// Writeback stage and 32 x 32-bit integer register file for the RV32I pipeline.
// Selects load/ALU writeback data, commits it, and serves two bypassed read ports.
module writeback_regfile #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   regWrite_Wb_In,
    input  logic                   memToRegWrite_Wb_In,
    input  logic [31:0]            readD_Wb_In,
    input  logic [31:0]            aluOut_Wb_In,
    input  logic [4:0]             rd_Wb_In,
    input  logic [4:0]             rs1_Id_In,
    input  logic [4:0]             rs2_Id_In,
    output logic [31:0]            rs1Data_Id_Out,
    output logic [31:0]            rs2Data_Id_Out,
    output logic [31:0]            wbData_Out,
    output logic                   wbValid_Out,
    output logic [COUNT_WIDTH-1:0] wbCount_Out
);

    localparam int NUM_REGS = 32;

    logic [31:0]                w_wbData;
    logic                       w_wbValid;
    logic [NUM_REGS-1:1][31:0]  r_regs;
    logic [NUM_REGS-1:0][31:0]  w_rdArr;
    logic [COUNT_WIDTH-1:0]     r_count;

    assign w_wbData  = memToRegWrite_Wb_In ? readD_Wb_In : aluOut_Wb_In;
    assign w_wbValid = regWrite_Wb_In & (rd_Wb_In != 5'd0);

    // x0 is never stored; slot 0 of the read view is hard-wired to zero.
    assign w_rdArr[0] = 32'd0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN)
                r_regs[g] <= 32'd0;
            else if (w_wbValid && (rd_Wb_In == 5'(g)))
                r_regs[g] <= w_wbData;
        end
        assign w_rdArr[g] = r_regs[g];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            r_count <= '0;
        else if (w_wbValid)
            r_count <= r_count + COUNT_WIDTH'(1);
    end

    // Bypass lets decode see a value retiring this same cycle.
    function automatic logic [31:0] read_port(input logic [4:0] rs);
        logic [31:0] v;
        if (rs == 5'd0)
            v = 32'd0;
        else if (w_wbValid && (rd_Wb_In == rs))
            v = w_wbData;
        else
            v = w_rdArr[rs];
        return v;
    endfunction

    assign rs1Data_Id_Out = read_port(rs1_Id_In);
    assign rs2Data_Id_Out = read_port(rs2_Id_In);
    assign wbData_Out     = w_wbData;
    assign wbValid_Out    = w_wbValid;
    assign wbCount_Out    = r_count;

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and integer register file for the 5-stage RV32I pipeline. Consumes the registered MEM/WB control and data signals, selects the writeback value (load data or ALU result), commits it to a 32 x 32-bit register file, and serves two read ports to the decode stage. Same-cycle write-to-read bypass is built in, so decode never sees stale data for an instruction retiring in the same cycle. A committed-write counter is kept for performance monitoring.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of the committed-write counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstN  input  1  reset, asynchronous, active-low
- regWrite_Wb_In  input  1  write enable from MEM/WB register
- memToRegWrite_Wb_In  input  1  1 = write load data, 0 = write ALU result
- readD_Wb_In  input  32  load data from MEM/WB register
- aluOut_Wb_In  input  32  ALU result from MEM/WB register
- rd_Wb_In  input  5  destination register index
- rs1_Id_In  input  5  decode read port 1 index
- rs2_Id_In  input  5  decode read port 2 index
- rs1Data_Id_Out  output  32  read port 1 data (combinational)
- rs2Data_Id_Out  output  32  read port 2 data (combinational)
- wbData_Out  output  32  selected writeback value, for EX-stage forwarding
- wbValid_Out  output  1  1 when a real write (regWrite=1, rd!=0) is in WB this cycle
- wbCount_Out  output  COUNT_WIDTH  number of committed writes since reset

## Operation
- wbData_Out = memToRegWrite_Wb_In ? readD_Wb_In : aluOut_Wb_In; combinational, independent of regWrite.
- wbValid_Out = regWrite_Wb_In & (rd_Wb_In != 0); combinational.
- Register file: x1..x31 are flops; x0 is not stored and always reads 0.
- On rising clk with wbValid_Out=1: regs[rd_Wb_In] <= wbData_Out. Writes to rd=0 discarded silently, not counted.
- Read port n (n=1,2), priority order:
  - rsn=0 -> 0
  - wbValid_Out & rd_Wb_In==rsn -> wbData_Out (bypass)
  - else regs[rsn]
- Both ports may address the same register and the write target simultaneously; both return the bypassed value.
- wbCount_Out increments by 1 on each rising clk with wbValid_Out=1; wraps from 2^COUNT_WIDTH-1 to 0 without flag.
- No stall or flush inputs: bubbles arrive as regWrite_Wb_In=0 and cause no state change.
- X on data inputs while regWrite_Wb_In=0 must not corrupt state.

## Timing
- Reset (rstN=0, asynchronous, immediate): x1..x31 <= 0, wbCount_Out <= 0. Combinational outputs follow inputs during reset, but bypass stays active (outputs derived from inputs), and register contents read as 0.
- Writes blocked while rstN=0; reset asserted mid-write wins, and the register reads 0 after the edge.
- Reset release is synchronous-safe: the first write is accepted on the first rising edge with rstN=1.
- Write latency: 1 cycle into array; 0 cycles visible at read ports via bypass.
- Read ports: purely combinational from rs indices and WB inputs; no registered output stage.
- Counter update is in the same edge as the array write.

## Test plan
- Reset: drive rstN=0 mid-run after writing x5=0xDEADBEEF -> rs1=5 reads 0 immediately, wbCount_Out=0; after release all x1..x31 read 0.
- ALU vs load select: regWrite=1, rd=3, aluOut=0x11, readD=0x22, memToReg=0 then rd=4 memToReg=1 -> x3=0x11, x4=0x22, wbCount_Out=2.
- x0 protection: regWrite=1, rd=0, aluOut=0xFFFFFFFF -> rs1=rs2=0 read 0, wbValid_Out=0, wbCount_Out unchanged.
- Bypass: x7 holds 0x100; same cycle regWrite=1, rd=7, aluOut=0x200, rs1=rs2=7 -> both ports 0x200 before edge; 0x200 persists after edge with regWrite=0.
- Bubble: regWrite=0, rd=9, aluOut=0xABCD, rs1=9 -> rs1Data=old x9, x9 unchanged after edge, counter unchanged.
- Counter wrap with COUNT_WIDTH=4: 17 valid writes -> wbCount_Out=1.
